// File: rtl/motor_de_puertas_if.sv
// Door motor bus: command/sensor inputs towards the controller and the
// registered door status coming back from it.
interface motor_de_puertas_if;
   logic [1:0] salida_puertas;  // 00 none, 01 open, 10 close, 11 none
   logic       sensor;          // obstacle between the doors
   logic [1:0] puertas;         // 00 closed, 01 open, 10 opening, 11 closing
   logic       timeout;         // doors have been open long enough
   logic [3:0] posicion;        // travel, 0 = closed, T_MOV = fully open
   logic       obstruccion;     // one-cycle pulse on a sensor-caused reopen

   // Side that issues commands and watches the doors
   modport master (
      output salida_puertas,
      output sensor,
      input  puertas,
      input  timeout,
      input  posicion,
      input  obstruccion
   );

   // Door controller side
   modport slave (
      input  salida_puertas,
      input  sensor,
      output puertas,
      output timeout,
      output posicion,
      output obstruccion
   );
endinterface

// File: rtl/motor_de_puertas.sv
// Door motor controller: four-state FSM whose state code is the door
// status itself. Strokes take T_MOV cycles, an open door raises timeout
// after T_ABIERTA cycles, and a closing stroke reverses on an obstacle
// or an open command. Every output comes straight from a register.
module motor_de_puertas #(
   parameter int T_MOV     = 4,   // 1..15
   parameter int T_ABIERTA = 8    // 1..255
) (
   input logic             clk,
   input logic             reset,
   motor_de_puertas_if.slave bus
);

   typedef enum logic [1:0] {
      CERRADA  = 2'b00,
      ABIERTA  = 2'b01,
      ABRIENDO = 2'b10,
      CERRANDO = 2'b11
   } estado_t;

   localparam logic [3:0] POS_MAX = 4'(T_MOV);
   localparam logic [7:0] CNT_MAX = 8'(T_ABIERTA);

   estado_t    estado;
   logic [3:0] posicion;
   logic [7:0] cuenta;       // cycles spent fully open, saturating
   logic       timeout;
   logic       obstruccion;

   logic       orden_abrir;
   logic       orden_cerrar;
   logic [7:0] cuenta_inc;
   logic       fin_apertura;
   logic       fin_cierre;

   // Command 11 decodes to neither, so it behaves like 00
   assign orden_abrir  = (bus.salida_puertas == 2'b01);
   assign orden_cerrar = (bus.salida_puertas == 2'b10);

   // Open counter saturates at T_ABIERTA so timeout stays up while idle
   assign cuenta_inc = (cuenta >= CNT_MAX) ? CNT_MAX : cuenta + 8'd1;

   // Opening ends on the edge that reaches T_MOV. The >= also covers a
   // reopen that starts already at T_MOV (reversal on the very first
   // closing edge), so travel can never exceed the fully-open point.
   assign fin_apertura = (posicion >= POS_MAX - 4'd1);

   // Closing ends on the edge that brings travel down to 0
   assign fin_cierre = (posicion <= 4'd1);

   // Door FSM with all outputs registered alongside the state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado      <= CERRADA;
         posicion    <= 4'd0;
         cuenta      <= 8'd0;
         timeout     <= 1'b0;
         obstruccion <= 1'b0;
      end else begin
         obstruccion <= 1'b0;
         case (estado)
            CERRADA: begin
               // Only an open command matters; sensor is irrelevant here
               if (orden_abrir) begin
                  estado   <= ABRIENDO;
                  posicion <= 4'd0;
               end
            end

            ABRIENDO: begin
               // Open strokes always complete; inputs are ignored
               if (fin_apertura) begin
                  estado   <= ABIERTA;
                  posicion <= POS_MAX;
                  cuenta   <= 8'd0;
                  timeout  <= 1'b0;
               end else begin
                  posicion <= posicion + 4'd1;
               end
            end

            ABIERTA: begin
               if (orden_abrir) begin
                  // Hold-open: restart the open time
                  cuenta  <= 8'd0;
                  timeout <= 1'b0;
               end else if (orden_cerrar && bus.sensor) begin
                  // Obstacle blocks the close; treat it as a fresh open
                  cuenta  <= 8'd0;
                  timeout <= 1'b0;
               end else if (orden_cerrar) begin
                  estado  <= CERRANDO;
                  cuenta  <= 8'd0;
                  timeout <= 1'b0;
               end else begin
                  cuenta  <= cuenta_inc;
                  timeout <= (cuenta_inc == CNT_MAX);
               end
            end

            CERRANDO: begin
               if (bus.sensor) begin
                  // Sensor wins over any command and is flagged
                  estado      <= ABRIENDO;
                  obstruccion <= 1'b1;
               end else if (orden_abrir) begin
                  estado <= ABRIENDO;
               end else if (fin_cierre) begin
                  estado   <= CERRADA;
                  posicion <= 4'd0;
               end else begin
                  posicion <= posicion - 4'd1;
               end
            end

            default: begin
               estado   <= CERRADA;
               posicion <= 4'd0;
               cuenta   <= 8'd0;
               timeout  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.puertas     = estado;
   assign bus.posicion    = posicion;
   assign bus.timeout     = timeout;
   assign bus.obstruccion = obstruccion;

endmodule
